vec_alu_seq: RTL

VEC_ALU_SEQ -- requirements
Module: vec_alu_seq

---
 rtl/vec_alu_pkg.sv | 40 ++++
 rtl/vec_alu_seq_if.sv | 53 +++++
 rtl/vec_lane_merge.sv | 29 ++
 rtl/vec_alu_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/vec_alu_pkg.sv
// Shared definitions for the vector ALU sequencer and its lanes.
// Holds the opcode/operand-form constants, element-width codes and FSM states.
package vec_alu_pkg;

    localparam logic [5:0] OP_VADD = 6'b000000;
    localparam logic [5:0] OP_VAND = 6'b001001;
    localparam logic [5:0] OP_VOR  = 6'b001010;
    localparam logic [5:0] OP_VXOR = 6'b001011;

    localparam logic [2:0] OPT_VV = 3'b001;
    localparam logic [2:0] OPT_VX = 3'b010;
    localparam logic [2:0] OPT_VI = 3'b100;

    typedef enum logic [2:0] {
        SEW_8  = 3'd0,
        SEW_16 = 3'd1,
        SEW_32 = 3'd2,
        SEW_64 = 3'd3
    } vsew_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RESP
    } state_e;

    function automatic logic req_legal(input logic [5:0] opcode,
                                       input logic [2:0] vsew,
                                       input logic [2:0] op_type);
        logic op_ok;
        logic sew_ok;
        logic type_ok;
        op_ok   = (opcode == OP_VADD) || (opcode == OP_VAND) ||
                  (opcode == OP_VOR)  || (opcode == OP_VXOR);
        sew_ok  = (vsew <= SEW_64);
        type_ok = (op_type == OPT_VV) || (op_type == OPT_VX) || (op_type == OPT_VI);
        return op_ok && sew_ok && type_ok;
    endfunction

endpackage

// File: rtl/vec_alu_seq_if.sv
// Request, lane and response bundle between the sequencer and its environment.
// The sequencer uses the slave view; requester plus lanes use the master view.
interface vec_alu_seq_if #(
    parameter int unsigned VLEN    = 128,
    parameter int unsigned NL_LOG2 = 2
);
    localparam int unsigned NL = 1 << NL_LOG2;

    logic                 req_valid;
    logic                 req_ready;
    logic [5:0]           req_opcode;
    logic [2:0]           req_vsew;
    logic [2:0]           req_op_type;
    logic [VLEN-1:0]      req_vs1;
    logic [VLEN-1:0]      req_vs2;

    logic                 lane_run;
    logic [5:0]           lane_opcode;
    logic [2:0]           lane_vsew;
    logic [2:0]           lane_op_type;
    logic [1:0]           lane_nb_lanes;
    logic [VLEN-1:0]      lane_vs1;
    logic [VLEN-1:0]      lane_vs2;
    logic [NL-1:0]        lane_done;
    logic [NL*VLEN-1:0]   lane_vd;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [VLEN-1:0]      rsp_vd;
    logic                 rsp_err;
    logic [15:0]          rsp_cycles;

    modport slave (
        input  req_valid, req_opcode, req_vsew, req_op_type, req_vs1, req_vs2,
        output req_ready,
        output lane_run, lane_opcode, lane_vsew, lane_op_type, lane_nb_lanes,
        output lane_vs1, lane_vs2,
        input  lane_done, lane_vd,
        output rsp_valid, rsp_vd, rsp_err, rsp_cycles,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_opcode, req_vsew, req_op_type, req_vs1, req_vs2,
        input  req_ready,
        input  lane_run, lane_opcode, lane_vsew, lane_op_type, lane_nb_lanes,
        input  lane_vs1, lane_vs2,
        output lane_done, lane_vd,
        input  rsp_valid, rsp_vd, rsp_err, rsp_cycles,
        output rsp_ready
    );

endinterface

// File: rtl/vec_lane_merge.sv
// Element merge: element e of width SEW is taken from lane (e mod NL).
// Works per byte, since every SEW is a whole number of bytes.
module vec_lane_merge
    import vec_alu_pkg::*;
#(
    parameter int unsigned VLEN    = 128,
    parameter int unsigned NL_LOG2 = 2
) (
    input  vsew_e                            vsew_i,
    input  logic [(VLEN << NL_LOG2)-1:0]     lane_vd_i,
    output logic [VLEN-1:0]                  vd_o
);
    localparam int unsigned NL     = 1 << NL_LOG2;
    localparam int unsigned NBYTES = VLEN / 8;

    for (genvar b = 0; b < NBYTES; b++) begin : g_byte
        // Owning lane of this byte for each element width.
        localparam int unsigned L8  = (b / 1) % NL;
        localparam int unsigned L16 = (b / 2) % NL;
        localparam int unsigned L32 = (b / 4) % NL;
        localparam int unsigned L64 = (b / 8) % NL;
        assign vd_o[b*8 +: 8] =
            (vsew_i == SEW_8)  ? lane_vd_i[L8*VLEN  + b*8 +: 8] :
            (vsew_i == SEW_16) ? lane_vd_i[L16*VLEN + b*8 +: 8] :
            (vsew_i == SEW_32) ? lane_vd_i[L32*VLEN + b*8 +: 8] :
                                 lane_vd_i[L64*VLEN + b*8 +: 8];
    end

endmodule

// File: rtl/vec_alu_seq.sv
// Vector ALU sequencer: accepts one request, runs the lanes until all are done
// or the timeout expires, merges lane results and holds the response.
module vec_alu_seq
    import vec_alu_pkg::*;
#(
    parameter int unsigned VLEN       = 128,
    parameter int unsigned NL_LOG2    = 2,
    parameter int unsigned LANE_WIDTH = 3,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         reset,
    vec_alu_seq_if.slave bus
);
    if (VLEN < 64 || (VLEN % (1 << LANE_WIDTH)) != 0) begin : g_bad_cfg
        $error("vec_alu_seq: VLEN must be >= 64 and a multiple of the lane width");
    end

    state_e          state_q, state_d;
    logic [5:0]      opcode_q, opcode_d;
    logic [2:0]      vsew_q, vsew_d;
    logic [2:0]      optype_q, optype_d;
    logic [VLEN-1:0] vs1_q, vs1_d;
    logic [VLEN-1:0] vs2_q, vs2_d;
    logic [VLEN-1:0] vd_q, vd_d;
    logic            err_q, err_d;
    logic [15:0]     cycles_q, cycles_d;

    logic [VLEN-1:0] merged;
    logic [VLEN-1:0] lane_vs1_w;
    logic [15:0]     cycles_inc;
    logic            timeout_hit;

    vec_lane_merge #(.VLEN(VLEN), .NL_LOG2(NL_LOG2)) u_merge (
        .vsew_i    (vsew_e'(vsew_q)),
        .lane_vd_i (bus.lane_vd),
        .vd_o      (merged)
    );

    assign cycles_inc  = (cycles_q == 16'hFFFF) ? cycles_q : cycles_q + 16'd1;
    assign timeout_hit = ({16'd0, cycles_q} >= TIMEOUT);

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        vsew_d   = vsew_q;
        optype_d = optype_q;
        vs1_d    = vs1_q;
        vs2_d    = vs2_q;
        vd_d     = vd_q;
        err_d    = err_q;
        cycles_d = cycles_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    opcode_d = bus.req_opcode;
                    vsew_d   = bus.req_vsew;
                    optype_d = bus.req_op_type;
                    vs1_d    = bus.req_vs1;
                    vs2_d    = bus.req_vs2;
                    vd_d     = '0;
                    if (req_legal(bus.req_opcode, bus.req_vsew, bus.req_op_type)) begin
                        state_d  = ST_RUN;
                        err_d    = 1'b0;
                        cycles_d = 16'd1;
                    end else begin
                        state_d  = ST_RESP;
                        err_d    = 1'b1;
                        cycles_d = '0;
                    end
                end
            end
            ST_RUN: begin
                // Completion is tested first so it wins over a coincident timeout.
                if (&bus.lane_done) begin
                    vd_d    = merged;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    vd_d    = '0;
                    state_d = ST_RESP;
                end else begin
                    cycles_d = cycles_inc;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
            vsew_q   <= '0;
            optype_q <= '0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            vd_q     <= '0;
            err_q    <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            vsew_q   <= vsew_d;
            optype_q <= optype_d;
            vs1_q    <= vs1_d;
            vs2_q    <= vs2_d;
            vd_q     <= vd_d;
            err_q    <= err_d;
            cycles_q <= cycles_d;
        end
    end

    // Scalar forms keep only the low 64 bits; the immediate is sign-extended to 64.
    always_comb begin
        lane_vs1_w = vs1_q;
        if (optype_q == OPT_VX) begin
            lane_vs1_w        = '0;
            lane_vs1_w[63:0]  = vs1_q[63:0];
        end else if (optype_q == OPT_VI) begin
            lane_vs1_w        = '0;
            lane_vs1_w[63:0]  = {{59{vs1_q[4]}}, vs1_q[4:0]};
        end
    end

    assign bus.req_ready     = (state_q == ST_IDLE);
    assign bus.lane_run      = (state_q == ST_RUN);
    assign bus.rsp_valid     = (state_q == ST_RESP);
    assign bus.lane_opcode   = opcode_q;
    assign bus.lane_vsew     = vsew_q;
    assign bus.lane_op_type  = optype_q;
    assign bus.lane_nb_lanes = 2'(NL_LOG2);
    assign bus.lane_vs1      = lane_vs1_w;
    assign bus.lane_vs2      = vs2_q;
    assign bus.rsp_vd        = vd_q;
    assign bus.rsp_err       = err_q;
    assign bus.rsp_cycles    = cycles_q;

endmodule
